// File: rtl/graphics_package.sv
// graphics_package: shared 640x480 raster timing and the
// sync bundle that travels alongside rendered pixels.
package graphics_package;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // v inside [lo, lo+len)
  function automatic logic in_range(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage en-gated shift of a sync_t bundle.
// Ports: clk_i, rst_ni (async, loads RST_VAL), en_i, d_i, q_o.
module sync_delay_line
  import graphics_package::*;
#(
  parameter int    DEPTH   = 2,
  parameter sync_t RST_VAL = '0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  sync_t d_i,
  output sync_t q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = ^{clk_i, rst_ni, en_i};
    assign q_o    = d_i;
  end else begin : g_pipe
    sync_t stg_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          stg_q[i] <= RST_VAL;
        end
      end else if (en_i) begin
        stg_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stg_q[i] <= stg_q[i-1];
        end
      end
    end

    assign q_o = stg_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, active/line/frame decode and
// hsync/vsync/de delayed by PIPE_DELAY to line up with renderer RGB.
// Ports: pix_clk, rst_n (async), en; pos_x, pos_y, active,
// line_start, frame_start (undelayed); hsync, vsync, de (delayed).
module video_timing_gen #(
  parameter int H_ACTIVE   = graphics_package::H_ACTIVE,
  parameter int H_FP       = graphics_package::H_FP,
  parameter int H_SYNC     = graphics_package::H_SYNC,
  parameter int H_BP       = graphics_package::H_BP,
  parameter int V_ACTIVE   = graphics_package::V_ACTIVE,
  parameter int V_FP       = graphics_package::V_FP,
  parameter int V_SYNC     = graphics_package::V_SYNC,
  parameter int V_BP       = graphics_package::V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic           pix_clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           active,
  output logic           line_start,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic           de
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("video_timing_gen: porch/sync widths must be >= 1");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("video_timing_gen: PIPE_DELAY must be 0..8");
  end

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;

  localparam graphics_package::sync_t IDLE = '{
    hs: ~HS_POL,
    vs: ~VS_POL,
    de: 1'b0
  };

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  logic           h_last, v_last;

  assign h_last = (h_q == X_W'(H_TOTAL - 1));
  assign v_last = (v_q == Y_W'(V_TOTAL - 1));

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (en) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic h_act, v_act, hs_on, vs_on;
  graphics_package::sync_t raw, dly;

  assign h_act = int'(h_q) < H_ACTIVE;
  assign v_act = int'(v_q) < V_ACTIVE;
  assign hs_on = graphics_package::in_range(int'(h_q), HS_BEG, H_SYNC);
  assign vs_on = graphics_package::in_range(int'(v_q), VS_BEG, V_SYNC);

  assign raw.hs = hs_on ? HS_POL : ~HS_POL;
  assign raw.vs = vs_on ? VS_POL : ~VS_POL;
  assign raw.de = h_act && v_act;

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk_i  (pix_clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .d_i    (raw),
    .q_o    (dly)
  );

  assign pos_x       = h_q;
  assign pos_y       = v_q;
  assign active      = raw.de;
  assign line_start  = (h_q == '0);
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign hsync       = dly.hs;
  assign vsync       = dly.vs;
  assign de          = dly.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three builds (default, small/odd polarity,
// PIPE_DELAY=0) checked each cycle against an arithmetic raster model.
module tb_video_timing_gen;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
    bit hp, vp;
  } tcfg_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic act, ls, fs, hs, vs, de;
  } obs_t;

  localparam tcfg_t CDEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
  localparam tcfg_t CSML = '{6, 2, 3, 2, 4, 1, 2, 1, 3, 1'b1, 1'b0};
  localparam tcfg_t CD0  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, 1'b0};

  logic pix_clk = 1'b0;
  logic rst_n;
  logic en;

  logic [9:0] def_x, def_y, d0_x, d0_y;
  logic [3:0] sml_x;
  logic [2:0] sml_y;
  logic def_act, def_ls, def_fs, def_hs, def_vs, def_de;
  logic sml_act, sml_ls, sml_fs, sml_hs, sml_vs, sml_de;
  logic d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_de;

  int checks = 0;
  int errors = 0;
  longint n = 0;

  always #5 pix_clk = ~pix_clk;

  video_timing_gen u_def (
    .pix_clk(pix_clk), .rst_n(rst_n), .en(en),
    .pos_x(def_x), .pos_y(def_y), .active(def_act),
    .line_start(def_ls), .frame_start(def_fs),
    .hsync(def_hs), .vsync(def_vs), .de(def_de)
  );

  video_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DELAY(3)
  ) u_sml (
    .pix_clk(pix_clk), .rst_n(rst_n), .en(en),
    .pos_x(sml_x), .pos_y(sml_y), .active(sml_act),
    .line_start(sml_ls), .frame_start(sml_fs),
    .hsync(sml_hs), .vsync(sml_vs), .de(sml_de)
  );

  video_timing_gen #(.PIPE_DELAY(0)) u_d0 (
    .pix_clk(pix_clk), .rst_n(rst_n), .en(en),
    .pos_x(d0_x), .pos_y(d0_y), .active(d0_act),
    .line_start(d0_ls), .frame_start(d0_fs),
    .hsync(d0_hs), .vsync(d0_vs), .de(d0_de)
  );

  obs_t o_def, o_sml, o_d0;
  assign o_def = '{16'(def_x), 16'(def_y), def_act, def_ls, def_fs,
                   def_hs, def_vs, def_de};
  assign o_sml = '{16'(sml_x), 16'(sml_y), sml_act, sml_ls, sml_fs,
                   sml_hs, sml_vs, sml_de};
  assign o_d0  = '{16'(d0_x), 16'(d0_y), d0_act, d0_ls, d0_fs,
                   d0_hs, d0_vs, d0_de};

  // Expected outputs after k enabled edges since reset release.
  function automatic obs_t model(tcfg_t c, longint k);
    obs_t o;
    int ht, vt, x, y, mx, my;
    longint m;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    x = int'(k % ht);
    y = int'((k / ht) % vt);
    o.x = 16'(x);
    o.y = 16'(y);
    o.act = (x < c.ha) && (y < c.va);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    o.hs = !c.hp;
    o.vs = !c.vp;
    o.de = 1'b0;
    if (k >= c.d) begin
      m = k - c.d;
      mx = int'(m % ht);
      my = int'((m / ht) % vt);
      if (mx >= c.ha + c.hf && mx < c.ha + c.hf + c.hs) o.hs = c.hp;
      if (my >= c.va + c.vf && my < c.va + c.vf + c.vs) o.vs = c.vp;
      o.de = (mx < c.ha) && (my < c.va);
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else if (en) n <= n + 1;
  end

  logic en_edge = 1'b0;
  always @(posedge pix_clk) en_edge <= en;

  obs_t prev_def;
  bit have_prev = 1'b0;

  always @(negedge pix_clk) begin
    chk("cyc_def", o_def, model(CDEF, n));
    chk("cyc_sml", o_sml, model(CSML, n));
    chk("cyc_d0", o_d0, model(CD0, n));
    chk("d0_de_eq_active", d0_de, d0_act);
    if (rst_n && have_prev && !en_edge) chk("hold_def", o_def, prev_def);
    prev_def = o_def;
    have_prev = rst_n;
  end

  // Event timing measured in clocks since reset release.
  int s;
  int hs_fall1_def, hs_lo_st_def, hs_lo_len_def, ls_last_def, ls_per_def;
  int hs_fall1_d0;
  int vs_fall1_sml, vs_lo_st_sml, vs_lo_len_sml;
  int fs_last_sml, fs_per_sml, de_acc_sml, de_frm_sml;
  int hs_hi_st_sml, hs_hi_len_sml;
  logic p_hs_def, p_ls_def, p_hs_d0, p_vs_sml, p_fs_sml, p_hs_sml;

  always @(negedge pix_clk) begin
    if (!rst_n) begin
      s = -1;
      hs_fall1_def = -1; hs_lo_st_def = -1; hs_lo_len_def = -1;
      ls_last_def = -1; ls_per_def = -1; hs_fall1_d0 = -1;
      vs_fall1_sml = -1; vs_lo_st_sml = -1; vs_lo_len_sml = -1;
      fs_last_sml = -1; fs_per_sml = -1; de_acc_sml = 0; de_frm_sml = -1;
      hs_hi_st_sml = -1; hs_hi_len_sml = -1;
    end else begin
      s++;
      if (p_hs_def && !def_hs) begin
        hs_lo_st_def = s;
        if (hs_fall1_def < 0) hs_fall1_def = s;
      end
      if (!p_hs_def && def_hs && hs_lo_st_def >= 0)
        hs_lo_len_def = s - hs_lo_st_def;
      if (def_ls && (!p_ls_def || s == 0)) begin
        if (ls_last_def >= 0) ls_per_def = s - ls_last_def;
        ls_last_def = s;
      end
      if (p_hs_d0 && !d0_hs && hs_fall1_d0 < 0) hs_fall1_d0 = s;
      if (p_vs_sml && !sml_vs) begin
        vs_lo_st_sml = s;
        if (vs_fall1_sml < 0) vs_fall1_sml = s;
      end
      if (!p_vs_sml && sml_vs && vs_lo_st_sml >= 0)
        vs_lo_len_sml = s - vs_lo_st_sml;
      if (sml_fs && (!p_fs_sml || s == 0)) begin
        if (fs_last_sml >= 0) begin
          fs_per_sml = s - fs_last_sml;
          de_frm_sml = de_acc_sml;
        end
        fs_last_sml = s;
        de_acc_sml = 0;
      end
      if (sml_de) de_acc_sml++;
      if (!p_hs_sml && sml_hs) hs_hi_st_sml = s;
      if (p_hs_sml && !sml_hs && hs_hi_st_sml >= 0)
        hs_hi_len_sml = s - hs_hi_st_sml;
    end
    p_hs_def = def_hs; p_ls_def = def_ls; p_hs_d0 = d0_hs;
    p_vs_sml = sml_vs; p_fs_sml = sml_fs; p_hs_sml = sml_hs;
  end

  task automatic pin(input string name, input tcfg_t c, input longint k,
                     input int field, input logic exp);
    obs_t t;
    logic v;
    t = model(c, k);
    case (field)
      0: v = t.hs;
      1: v = t.vs;
      2: v = t.de;
      3: v = t.fs;
      default: v = t.act;
    endcase
    chk(name, 64'(v), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    en = 1'b0;

    pin("pin_hs657", CDEF, 657, 0, 1'b1);
    pin("pin_hs658", CDEF, 658, 0, 1'b0);
    pin("pin_hs753", CDEF, 753, 0, 1'b0);
    pin("pin_hs754", CDEF, 754, 0, 1'b1);
    pin("pin_de1", CDEF, 1, 2, 1'b0);
    pin("pin_de2", CDEF, 2, 2, 1'b1);
    pin("pin_vs_pre", CDEF, 392001, 1, 1'b1);
    pin("pin_vs_on", CDEF, 392002, 1, 1'b0);
    pin("pin_vs_last", CDEF, 393601, 1, 1'b0);
    pin("pin_vs_off", CDEF, 393602, 1, 1'b1);
    pin("pin_fs_wrap", CDEF, 420000, 3, 1'b1);
    pin("pin_act640", CDEF, 640, 4, 1'b0);
    pin("pin_sml_vs68", CSML, 68, 1, 1'b0);
    pin("pin_d0_hs656", CD0, 656, 0, 1'b0);

    repeat (4) @(posedge pix_clk);
    #2;
    rst_n = 1'b1;
    en = 1'b1;

    @(negedge pix_clk); #1;
    chk("rel_x", def_x, 0);
    chk("rel_y", def_y, 0);
    chk("rel_active", def_act, 1);
    chk("rel_fs", def_fs, 1);
    chk("rel_hsync", def_hs, 1);
    chk("rel_de0", def_de, 0);
    @(negedge pix_clk); #1;
    chk("rel_de1", def_de, 0);
    @(negedge pix_clk); #1;
    chk("rel_de2", def_de, 1);

    repeat (1700) @(negedge pix_clk);
    #1;
    chk("hs_fall_def", hs_fall1_def, 658);
    chk("hs_low_def", hs_lo_len_def, 96);
    chk("ls_period", ls_per_def, 800);
    chk("hs_fall_d0", hs_fall1_d0, 656);
    chk("vs_fall_sml", vs_fall1_sml, 68);
    chk("vs_low_sml", vs_lo_len_sml, 26);
    chk("fs_period_sml", fs_per_sml, 104);
    chk("de_frame_sml", de_frm_sml, 24);
    chk("hs_high_sml", hs_hi_len_sml, 3);

    for (int i = 0; i < 2500; i++) begin
      @(posedge pix_clk); #2; en = 1'b0;
      @(posedge pix_clk); #2; en = 1'b1;
    end
    @(negedge pix_clk); #1;
    chk("ls_period_en", ls_per_def, 1600);
    chk("hs_low_en", hs_lo_len_def, 192);
    chk("fs_period_en", fs_per_sml, 208);
    chk("vs_low_en", vs_lo_len_sml, 52);
    chk("de_frame_en", de_frm_sml, 48);
    chk("hs_high_en", hs_hi_len_sml, 6);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge pix_clk); #1;
      if (def_x == 10'd400) found = 1'b1;
    end
    chk("wait_x400", found, 1);

    @(posedge pix_clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", def_x, 0);
    chk("arst_y", def_y, 0);
    chk("arst_hs", def_hs, 1);
    chk("arst_vs", def_vs, 1);
    chk("arst_de", def_de, 0);
    chk("arst_act", def_act, 1);
    chk("arst_sml_hs", sml_hs, 0);
    chk("arst_sml_de", sml_de, 0);
    repeat (3) @(posedge pix_clk);
    #2;
    rst_n = 1'b1;

    @(negedge pix_clk); #1;
    chk("rst2_x", def_x, 0);
    chk("rst2_fs", def_fs, 1);
    chk("rst2_de0", def_de, 0);
    @(negedge pix_clk); #1;
    chk("rst2_de1", def_de, 0);
    @(negedge pix_clk); #1;
    chk("rst2_de2", def_de, 1);

    repeat (800) @(negedge pix_clk);
    #1;
    chk("rst2_hs_fall", hs_fall1_def, 658);
    chk("rst2_vs_fall_sml", vs_fall1_sml, 68);
    chk("rst2_fs_period", fs_per_sml, 104);
    chk("rst2_de_frame", de_frm_sml, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
